// File: rtl/alu_pkg.sv
// Shared ALU op codes and arbiter FSM encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;

  // IDLE: nothing held; HOLD: response held on the output channel
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU. Shift amount is the full A operand, so any A >= WIDTH
// shifts everything out (zero, or sign fill for sra). Unknown ops give 0 + err.
module alu_share_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  // Decode op and compute the result
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = b << a;
      ALU_SRA: y = $signed(b) >>> a;
      ALU_SRL: y = b >> a;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU among NREQ requesters. One grant per cycle,
// result registered one cycle later and held on a valid/ready response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int WIDTH = 32,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  input  logic [NREQ-1:0][3:0]       req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_err,
  output logic [31:0]                busy_cycles
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt;
  logic [IDW-1:0]   idx;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] alu_y;
  logic             alu_err;

  assign can_accept = (state == IDLE) || rsp_ready;
  assign accept     = can_accept && found;

  // Search from rr_ptr, wrapping modulo NREQ; first valid requester wins
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // Ready only toward the granted requester, and only when a slot is free
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = accept && (gnt == IDW'(i));
  end

  alu_share_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (req_a[gnt]),
    .b   (req_b[gnt]),
    .op  (req_op[gnt]),
    .y   (alu_y),
    .err (alu_err)
  );

  // Response FSM: capture on accept, release on rsp_ready, count busy cycles
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_err     <= 1'b0;
      rr_ptr      <= '0;
      busy_cycles <= '0;
    end else begin
      if (accept) begin
        state      <= HOLD;
        rsp_valid  <= 1'b1;
        rsp_id     <= gnt;
        rsp_result <= alu_y;
        rsp_err    <= alu_err;
        rr_ptr     <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
      end else if (state == HOLD && rsp_ready) begin
        // result and err are left as-is; only valid drops
        state     <= IDLE;
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && busy_cycles != 32'hFFFF_FFFF)
        busy_cycles <= busy_cycles + 32'd1;
    end
  end

endmodule
